// File: rtl/ctl_long_carry.sv
// EBOX CTL long-carry sequencer: steps multi-word AD operations one word per cycle and generates the ADX carry-in and AR/ARX load strobes.
// Optional carry trace ports (carryHist, carrySticky) are built when CTL_CARRY_TRACE_EN is defined.
module ctl_long_carry #(
   parameter int NWORDS = 2,
   parameter int CNTW   = $clog2(NWORDS + 1)
) (
   input  logic            eboxClk,
   input  logic            eboxReset_n,
   input  logic            start,
   input  logic [CNTW-1:0] nWords,
   input  logic            abort,
   input  logic            hold,
   input  logic            CRAM_ADcarry,
   input  logic            spec_XCRY_AR0,
   input  logic            PCplus1inh,
   input  logic            AR0,
   input  logic            ADcarryOut,
   output logic            ADXcarry36,
   output logic            ADlong,
   output logic            busy,
   output logic            done,
   output logic [CNTW-1:0] wordIdx,
   output logic            CTL_ARX_LOAD,
   output logic            CTL_AR00to08load,
   output logic            CTL_AR09to17load,
   output logic            CTL_ARRload
`ifdef CTL_CARRY_TRACE_EN
   ,
   output logic [NWORDS-1:0] carryHist,
   output logic              carrySticky
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WORD = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t          state, state_nxt;
   logic [CNTW-1:0] idx;
   logic [CNTW-1:0] last;
   logic [CNTW-1:0] n_norm;
   logic            carry_q;
   logic            save_flags;
   logic            xcry;
   logic            cram;
   logic            word0_cin;
   logic            ar_load;
   logic            accept;
   logic            advance;
   logic            is_last;

   // Word count as actually run: zero means one word, oversize clamps to NWORDS.
   always_comb begin
      if (nWords == '0)
         n_norm = CNTW'(1);
      else if (nWords > CNTW'(NWORDS))
         n_norm = CNTW'(NWORDS);
      else
         n_norm = nWords;
   end

   assign accept    = (state == ST_IDLE) && start && !abort;
   assign is_last   = (idx == last);
   assign advance   = (state == ST_WORD) && !hold && !abort;
   assign word0_cin = ~save_flags & ((AR0 & xcry) ^ cram);

   // NOTE: the state register uses non-blocking assignment; the next-state
   // logic below is combinational, so every output gets a default first to
   // keep it latch-free.
   always_ff @(posedge eboxClk or negedge eboxReset_n) begin
      if (!eboxReset_n)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      busy         = 1'b0;
      done         = 1'b0;
      ADlong       = 1'b0;
      ADXcarry36   = 1'b0;
      CTL_ARX_LOAD = 1'b0;
      ar_load      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (accept)
               state_nxt = ST_WORD;
         end
         ST_WORD: begin
            busy       = 1'b1;
            ADlong     = (last != '0);
            ADXcarry36 = (idx == '0) ? word0_cin : carry_q;
            if (!hold) begin
               CTL_ARX_LOAD = !is_last;
               ar_load      = is_last;
            end
            if (abort)
               state_nxt = ST_IDLE;
            else if (!hold && is_last)
               state_nxt = ST_DONE;
         end
         ST_DONE: begin
            busy      = 1'b1;
            done      = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign CTL_AR00to08load = ar_load;
   assign CTL_AR09to17load = ar_load;
   assign CTL_ARRload      = ar_load;
   assign wordIdx          = idx;

   // Operation context: latched at start, word index and inter-word carry
   // stepped on each non-held WORD cycle.
   always_ff @(posedge eboxClk or negedge eboxReset_n) begin
      if (!eboxReset_n) begin
         idx        <= '0;
         last       <= '0;
         carry_q    <= 1'b0;
         save_flags <= 1'b0;
         xcry       <= 1'b0;
         cram       <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  idx        <= '0;
                  carry_q    <= 1'b0;
                  last       <= n_norm - CNTW'(1);
                  save_flags <= PCplus1inh & spec_XCRY_AR0;
                  xcry       <= spec_XCRY_AR0;
                  cram       <= CRAM_ADcarry;
               end
            end
            ST_WORD: begin
               if (abort) begin
                  idx     <= '0;
                  carry_q <= 1'b0;
               end else if (!hold && !is_last) begin
                  carry_q <= ADcarryOut;
                  idx     <= idx + CNTW'(1);
               end
            end
            default: begin
               idx     <= '0;
               carry_q <= 1'b0;
            end
         endcase
      end
   end

`ifdef CTL_CARRY_TRACE_EN
   always_ff @(posedge eboxClk or negedge eboxReset_n) begin
      if (!eboxReset_n) begin
         carryHist   <= '0;
         carrySticky <= 1'b0;
      end else begin
         if (accept)
            carryHist <= '0;
         else if (advance) begin
            for (int k = 0; k < NWORDS; k++) begin
               if (idx == CNTW'(k))
                  carryHist[k] <= ADcarryOut;
            end
         end
         if (advance && is_last && ADcarryOut)
            carrySticky <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_ctl_long_carry.sv
// Randomised self-checking bench for ctl_long_carry against a word-level reference model of the carry chain.
// Build with CTL_CARRY_TRACE_EN defined to also check the carry trace ports.
module tb_ctl_long_carry;
   localparam int NW = 4;
   localparam int CW = $clog2(NW + 1);

   logic          eboxClk;
   logic          eboxReset_n;
   logic          start;
   logic [CW-1:0] nWords;
   logic          abort;
   logic          hold;
   logic          CRAM_ADcarry;
   logic          spec_XCRY_AR0;
   logic          PCplus1inh;
   logic          AR0;
   logic          ADcarryOut;
   logic          ADXcarry36;
   logic          ADlong;
   logic          busy;
   logic          done;
   logic [CW-1:0] wordIdx;
   logic          CTL_ARX_LOAD;
   logic          CTL_AR00to08load;
   logic          CTL_AR09to17load;
   logic          CTL_ARRload;
`ifdef CTL_CARRY_TRACE_EN
   logic [NW-1:0] carryHist;
   logic          carrySticky;
`endif

   ctl_long_carry #(.NWORDS(NW), .CNTW(CW)) dut (
      .eboxClk          (eboxClk),
      .eboxReset_n      (eboxReset_n),
      .start            (start),
      .nWords           (nWords),
      .abort            (abort),
      .hold             (hold),
      .CRAM_ADcarry     (CRAM_ADcarry),
      .spec_XCRY_AR0    (spec_XCRY_AR0),
      .PCplus1inh       (PCplus1inh),
      .AR0              (AR0),
      .ADcarryOut       (ADcarryOut),
      .ADXcarry36       (ADXcarry36),
      .ADlong           (ADlong),
      .busy             (busy),
      .done             (done),
      .wordIdx          (wordIdx),
      .CTL_ARX_LOAD     (CTL_ARX_LOAD),
      .CTL_AR00to08load (CTL_AR00to08load),
      .CTL_AR09to17load (CTL_AR09to17load),
      .CTL_ARRload      (CTL_ARRload)
`ifdef CTL_CARRY_TRACE_EN
      ,
      .carryHist        (carryHist),
      .carrySticky      (carrySticky)
`endif
   );

   initial eboxClk = 1'b0;
   always #5 eboxClk = ~eboxClk;

   int            checks = 0;
   int            errors = 0;
   logic [NW-1:0] exp_hist;
   logic          exp_sticky;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge eboxClk);
      #1;
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_idx"}, wordIdx, 0);
      check({tag, "_cin"}, ADXcarry36, 0);
      check({tag, "_long"}, ADlong, 0);
      check({tag, "_arx"}, CTL_ARX_LOAD, 0);
      check({tag, "_ar"}, {CTL_AR00to08load, CTL_AR09to17load, CTL_ARRload}, 0);
   endtask

   // One complete long operation. ar0_fix/cout_fix < 0 mean random;
   // hold_mode 0 = none, 1 = random, 2 = exactly two held cycles at word 1.
   task automatic run_op(input int n_req, input logic cram, input logic xcry, input logic pci,
                         input int ar0_fix, input int hold_mode, input int cout_fix);
      int            n;
      int            k;
      int            cyc;
      int            held1;
      logic [NW-1:0] couts;
      logic          h;
      logic          a0;
      logic          co;
      logic          expcin;
      n     = (n_req == 0) ? 1 : ((n_req > NW) ? NW : n_req);
      couts = '0;
      start = 1'b1;
      abort = 1'b0;
      nWords = n_req[CW-1:0];
      CRAM_ADcarry  = cram;
      spec_XCRY_AR0 = xcry;
      PCplus1inh    = pci;
      hold = 1'($urandom);
      #2;
      check("idle_busy", busy, 0);
      check("idle_cin", ADXcarry36, 0);
      next_cycle();
      start = 1'b0;
      CRAM_ADcarry  = 1'($urandom);
      spec_XCRY_AR0 = 1'($urandom);
      PCplus1inh    = 1'($urandom);
      nWords        = CW'($urandom);
      exp_hist = '0;
      k = 0;
      cyc = 0;
      held1 = 0;
      while (1) begin
         if (cyc >= 64) begin
            check("word_timeout", cyc, 0);
            break;
         end
         if (hold_mode == 1)
            h = ($urandom_range(0, 3) == 0);
         else
            h = (hold_mode == 2) && (k == 1) && (held1 < 2);
         if (h && k == 1)
            held1++;
         a0 = (ar0_fix < 0) ? 1'($urandom) : ar0_fix[0];
         co = (cout_fix < 0) ? 1'($urandom) : cout_fix[k];
         hold = h;
         AR0 = a0;
         ADcarryOut = co;
         if (k == 0)
            expcin = (pci & xcry) ? 1'b0 : ((a0 & xcry) ^ cram);
         else
            expcin = couts[k-1];
         #2;
         check("word_busy", busy, 1);
         check("word_done", done, 0);
         check("word_idx", wordIdx, k);
         check("word_cin", ADXcarry36, expcin);
         check("word_long", ADlong, n > 1);
         check("word_arx", CTL_ARX_LOAD, !h && (k < n - 1));
         check("word_ar", {CTL_AR00to08load, CTL_AR09to17load, CTL_ARRload},
               (!h && (k == n - 1)) ? 3'b111 : 3'b000);
         next_cycle();
         cyc++;
         if (!h) begin
            couts[k]    = co;
            exp_hist[k] = co;
            if (k == n - 1) begin
               exp_sticky = exp_sticky | co;
               break;
            end
            k++;
         end
      end
      hold = 1'($urandom);
      #2;
      check("done_pulse", done, 1);
      check("done_busy", busy, 1);
      check("done_long", ADlong, 0);
      check("done_arx", CTL_ARX_LOAD, 0);
      check("done_ar", {CTL_AR00to08load, CTL_AR09to17load, CTL_ARRload}, 0);
`ifdef CTL_CARRY_TRACE_EN
      check("trace_hist", carryHist, exp_hist);
      check("trace_sticky", carrySticky, exp_sticky);
`endif
      next_cycle();
      hold = 1'b0;
      #2;
      check_quiet("after");
      next_cycle();
   endtask

   initial begin
      eboxReset_n = 1'b0;
      start = 1'b0;
      nWords = '0;
      abort = 1'b0;
      hold = 1'b0;
      CRAM_ADcarry = 1'b1;
      spec_XCRY_AR0 = 1'b1;
      PCplus1inh = 1'b0;
      AR0 = 1'b1;
      ADcarryOut = 1'b1;
      exp_hist = '0;
      exp_sticky = 1'b0;
      next_cycle();
      #2;
      check_quiet("reset");
      next_cycle();
      eboxReset_n = 1'b1;
      next_cycle();

      // Single word with CRAM carry.
      run_op(1, 1'b1, 1'b0, 1'b0, -1, 0, -1);
      // Three words, carries 1,0,x.
      run_op(3, 1'b0, 1'b1, 1'b0, 1, 0, 1);
      // PI-cycle save-flags inhibit on word 0.
      run_op(2, 1'b0, 1'b1, 1'b1, 1, 0, -1);
      // Two held cycles at word 1.
      run_op(3, 1'b1, 1'b1, 1'b0, -1, 2, -1);
      // Count normalisation boundaries.
      run_op(0, 1'b1, 1'b0, 1'b0, -1, 0, -1);
      run_op(7, 1'b0, 1'b1, 1'b0, -1, 0, -1);
      // Carries 1,1 over two words.
      run_op(2, 1'b0, 1'b0, 1'b0, -1, 0, 3);

      // Asynchronous reset at word 1 while carry and AR strobes would be 1.
      start = 1'b1; nWords = CW'(2); CRAM_ADcarry = 1'b0; spec_XCRY_AR0 = 1'b0; PCplus1inh = 1'b0;
      next_cycle();
      start = 1'b0; ADcarryOut = 1'b1; hold = 1'b0;
      next_cycle();
      #2;
      check("rst_pre_idx", wordIdx, 1);
      check("rst_pre_cin", ADXcarry36, 1);
      eboxReset_n = 1'b0;
      exp_sticky = 1'b0;
      #1;
      check_quiet("rst_mid");
      next_cycle();
      eboxReset_n = 1'b1;
      #2;
      check_quiet("rst_rel");
      next_cycle();

      // Abort at word 1 together with start and hold.
      start = 1'b1; nWords = CW'(3); CRAM_ADcarry = 1'b0; spec_XCRY_AR0 = 1'b0;
      next_cycle();
      start = 1'b0; ADcarryOut = 1'b1;
      next_cycle();
      abort = 1'b1; start = 1'b1; hold = 1'b1;
      #2;
      check("abort_idx", wordIdx, 1);
      check("abort_cin", ADXcarry36, 1);
      check("abort_long", ADlong, 1);
      check("abort_arx", CTL_ARX_LOAD, 0);
      next_cycle();
      start = 1'b0; abort = 1'b0; hold = 1'b0;
      #2;
      check_quiet("abort_next");
      next_cycle();
      #2;
      check_quiet("abort_idle");
      next_cycle();

      for (int i = 0; i < 24; i++)
         run_op($urandom_range(0, 7), 1'($urandom), 1'($urandom), 1'($urandom), -1, 1, -1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
